serial_adder_nbit: RTL and testbench

SERIAL_ADDER_NBIT -- requirements
Module: serial_adder_nbit

---
 rtl/serial_adder_nbit_pkg.sv | 9 +
 rtl/full_adder_1bit.sv | 11 +
 rtl/serial_adder_defs.vh | 7 +
 rtl/serial_adder_nbit.sv | 92 +++++++++
 tb/tb_serial_adder_nbit.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_nbit_pkg.sv
// serial_adder_nbit_pkg: state type for the bit-serial adder
package serial_adder_nbit_pkg;
`include "serial_adder_defs.vh"
    typedef enum logic [1:0] {
        IDLE = `SA_IDLE,
        RUN  = `SA_RUN,
        DONE = `SA_DONE
    } state_t;
endpackage

// File: rtl/full_adder_1bit.sv
// full_adder_1bit: combinational bit-slice cell of the serial adder
module full_adder_1bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder_defs.vh
// serial_adder_defs: FSM state encodings shared by RTL and bench
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH
`define SA_IDLE 2'd0
`define SA_RUN  2'd1
`define SA_DONE 2'd2
`endif

// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit: LSB-first bit-serial add/subtract with registered results
module serial_adder_nbit
    import serial_adder_nbit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic             c_q, cout_q, ovf_q, busy_q, done_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s, fa_co, last;
    logic [WIDTH-1:0] res_d;
    assign last  = cnt_q == CW'(WIDTH - 1);
    assign res_d = {fa_s, res_q[WIDTH-1:1]};
    full_adder_1bit u_fa (
        .x (a_q[0]),
        .y (b_q[0]),
        .ci(c_q),
        .s (fa_s),
        .co(fa_co)
    );
    // FSM: load on start, one bit per edge in RUN, publish result on the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{sub}};
                        c_q     <= sub;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= fa_co;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_co;
                        ovf_q   <= c_q ^ fa_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_serial_adder_nbit.sv
// tb_serial_adder_nbit: scoreboard bench for 8-bit and 4-bit serial adders
module tb_serial_adder_nbit;
`include "serial_adder_defs.vh"
    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       st8 = 1'b0, sb8 = 1'b0, st4 = 1'b0, sb4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic [3:0] a4 = '0, b4 = '0, s4;
    logic       co8, ov8, bz8, dn8, co4, ov4, bz4, dn4;
    exp_t       q8[$], q4[$];
    exp_t       last8;
    int         checks = 0, errors = 0;
    serial_adder_nbit #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .sub(sb8),
        .sum(s8), .cout(co8), .overflow(ov8), .busy(bz8), .done(dn8)
    );
    serial_adder_nbit #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .sub(sb4),
        .sum(s4), .cout(co4), .overflow(ov4), .busy(bz4), .done(dn4)
    );
    always #5 clk = ~clk;
    // Reference: unsigned result/carry from integer arithmetic, overflow from signed range
    function automatic exp_t model(input int w, input int a, input int b, input bit sub);
        int   m, r, sa, sb, sr;
        exp_t e;
        m   = 1 << w;
        r   = sub ? a + m - b : a + b;
        e.c = r >= m;
        e.s = 8'(r % m);
        sa  = a >= m / 2 ? a - m : a;
        sb  = b >= m / 2 ? b - m : b;
        sr  = sub ? sa - sb : sa + sb;
        e.v = (sr < -(m / 2)) || (sr >= m / 2);
        return e;
    endfunction
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask
    // Monitor: pop and compare on every done pulse; no partial results while busy
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (dn8) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w8 done with no pending op: sum %0h", s8);
                end else begin
                    e = q8.pop_front();
                    chk("w8 sum", s8, e.s);
                    chk("w8 cout", co8, e.c);
                    chk("w8 overflow", ov8, e.v);
                end
            end
            if (dn4) begin
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w4 done with no pending op: sum %0h", s4);
                end else begin
                    e = q4.pop_front();
                    chk("w4 sum", {4'h0, s4}, e.s);
                    chk("w4 cout", co4, e.c);
                    chk("w4 overflow", ov4, e.v);
                end
            end
            if (bz8) chk("w8 outputs zero while busy", {co8, ov8, s8}, 0);
            if (bz4) chk("w4 outputs zero while busy", {co4, ov4, s4}, 0);
        end
    end
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit push);
        a8 = a; b8 = b; sb8 = s; st8 = 1'b1;
        @(posedge clk);
        #1 st8 = 1'b0;
        if (push) begin
            last8 = model(8, int'(a), int'(b), s);
            q8.push_back(last8);
        end
    endtask
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s);
        a4 = a; b4 = b; sb4 = s; st4 = 1'b1;
        @(posedge clk);
        #1 st4 = 1'b0;
        q4.push_back(model(4, int'(a), int'(b), s));
    endtask
    task automatic wait_done(input bit w4, input int w);
        int n = 0, nb = 0;
        @(negedge clk);
        if (!w4) chk("w8 state in run", 64'(u8.state_q), 64'(`SA_RUN));
        while (!(w4 ? dn4 : dn8) && n < 100) begin
            if (w4 ? bz4 : bz8) nb++;
            n++;
            @(negedge clk);
        end
        chk(w4 ? "w4 done latency" : "w8 done latency", n, w);
        chk(w4 ? "w4 busy cycles" : "w8 busy cycles", nb, w);
        chk(w4 ? "w4 busy low at done" : "w8 busy low at done", w4 ? bz4 : bz8, 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    // Stimulus: directed cases, back-to-back, reset abort, random W8, exhaustive W4
    initial begin
        logic [7:0] da[5], db[5];
        logic       ds[5];
        int         m;
        bit         saw;
        da = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
        db = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
        ds = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset outputs w8", {s8, co8, ov8, bz8, dn8}, 0);
        chk("reset outputs w4", {s4, co4, ov4, bz4, dn4}, 0);
        chk("reset state w8", 64'(u8.state_q), 64'(`SA_IDLE));
        for (int i = 0; i < 5; i++) begin
            issue8(da[i], db[i], ds[i], 1'b1);
            wait_done(1'b0, 8);
            @(negedge clk);
            chk("w8 done single pulse", dn8, 0);
            chk("w8 sum held", s8, last8.s);
            chk("w8 cout held", co8, last8.c);
            chk("w8 overflow held", ov8, last8.v);
        end
        issue8(8'h33, 8'h44, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 begin a8 = 8'h11; b8 = 8'h22; st8 = 1'b1; end
        @(posedge clk);
        #1 st8 = 1'b0;
        m = 0;
        @(negedge clk);
        while (!dn8 && m < 60) begin
            m++;
            @(negedge clk);
        end
        chk("w8 first done after ignored start", m, 5);
        a8 = 8'h01; b8 = 8'h02; sb8 = 1'b0; st8 = 1'b1;
        @(posedge clk);
        #1 st8 = 1'b0;
        q8.push_back(model(8, 1, 2, 1'b0));
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!dn8 && m < 60);
        chk("w8 back-to-back done spacing", m, 9);
        chk("w8 back-to-back sum", s8, 8'h03);
        @(negedge clk);
        issue8(8'h5A, 8'h13, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("w8 abort busy", bz8, 0);
        chk("w8 abort done", dn8, 0);
        chk("w8 abort sum", s8, 0);
        chk("w8 abort state", 64'(u8.state_q), 64'(`SA_IDLE));
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw |= dn8;
        end
        chk("w8 no done after abort", saw, 0);
        issue8(8'h20, 8'h20, 1'b0, 1'b1);
        wait_done(1'b0, 8);
        chk("w8 post-abort sum", s8, 8'h40);
        repeat (40) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            wait_done(1'b0, 8);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int s = 0; s < 2; s++) begin
                    issue4(4'(a), 4'(b), 1'(s));
                    wait_done(1'b1, 4);
                end
        repeat (5) @(negedge clk);
        chk("w8 scoreboard drained", q8.size(), 0);
        chk("w4 scoreboard drained", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
